dtw_frame_writer: RTL and testbench
===================================

# dtw_frame_writer

Producer side of the DTW sample FIFO. It segments a signed sample stream into frames that run from one rising zero crossing to the next and writes each frame into the FIFO through its write port (data/wrreq). It then holds a frame-ready handshake so the control state machine can launch the DTW processor, which reads the FIFO. It sits between the acquisition front end and the FIFO, in place of the raw wrreq/data inputs of the top level.

## Interface
Parameters:
- DATA_W, 16, sample width (matches FIFO data width)
- USEDW_W, 7, FIFO usedw width; FIFO depth is 2**USEDW_W
- MAX_LEN, 64, maximum samples per frame (1..2**USEDW_W-1)

Ports:
- clk  in  1  system clock
- rst_geral  in  1  reset; one clock, reset asynchronous and active-high
- in_data  in  DATA_W  signed sample, two's complement
- in_valid  in  1  in_data valid this cycle; no backpressure to the source
- fifo_full  in  1  FIFO full flag
- fifo_usedw  in  USEDW_W  FIFO fill level
- fifo_data  out  DATA_W  FIFO write data, registered
- fifo_wrreq  out  1  FIFO write strobe, registered
- frame_done  out  1  frame complete, held until acknowledged
- frame_ack  in  1  consumer acknowledge of frame_done
- frame_len  out  USEDW_W  samples written in the completed frame; valid while frame_done
- frame_err  out  1  frame ended by overflow or truncation; valid while frame_done
- overflow  out  1  sticky; a sample was lost to a full FIFO
- drop_cnt  out  16  saturating count of valid samples not written while in HOLD

## Operation
- Sign tracking: the prev_neg register is updated on every in_valid, in every state, with in_data[DATA_W-1]. Its reset value is 0.
- Rising crossing event (rzc): in_valid & prev_neg & ~in_data[DATA_W-1].
- States: ARM, FILL, HOLD. Reset state is ARM.
- ARM:
  - Nothing is written.
  - On rzc, write the crossing sample, set cnt=1 and go to FILL.
- FILL:
  - On in_valid & ~rzc & ~eff_full: write the sample and increment cnt.
  - On rzc: do not write the sample. Latch frame_len=cnt, frame_err=0, go to HOLD.
  - On in_valid & ~rzc & eff_full: do not write. Set overflow, latch frame_len=cnt, frame_err=1, go to HOLD.
  - After a write that makes cnt==MAX_LEN: latch frame_len=MAX_LEN, frame_err=1, go to HOLD on the same edge as that write.
- eff_full = fifo_full | (fifo_wrreq & fifo_usedw == 2**USEDW_W-1). This covers the write pending in the output register.
- HOLD:
  - frame_done=1.
  - Each in_valid increments drop_cnt, saturating at 16'hFFFF. No writes.
  - On frame_ack go to ARM. The next frame needs a new rzc.
- Priority within FILL when conditions coincide: rzc is evaluated first, then eff_full, then MAX_LEN.
- Reset values, applied immediately on rst_geral: fifo_wrreq 0, fifo_data 0, frame_done 0, frame_len 0, frame_err 0, overflow 0, drop_cnt 0, prev_neg 0, cnt 0, state ARM. A frame in progress is discarded. Flushing the FIFO is the FIFO sclr's responsibility (it is tied to rst_geral).

## Timing
- Write latency: sample presented at edge N produces fifo_wrreq=1 and fifo_data=sample after edge N, i.e. during cycle N+1. At most one write per in_valid.
- fifo_wrreq is high for exactly one cycle per written sample.
- frame_done rises in the cycle after the terminating event. It falls in the cycle after frame_ack is sampled high. frame_len and frame_err are stable throughout.
- frame_ack is ignored outside HOLD.
- The last fifo_wrreq of a frame precedes or coincides with the rise of frame_done, never follows it.
- frame_ack and rzc on the same edge: the state is still HOLD at that edge, so the crossing is dropped (drop_cnt +1). A frame starts only on a later rzc.
- in_valid may be high on every cycle; sustained throughput is 1 sample/cycle.

## Structure
- The shared package holds:
  - the state encoding typedef (ARM/FILL/HOLD);
  - DATA_W/USEDW_W defaults, shared with the FIFO and the DTW top level.
- One sub-module: zc_detect (prev_neg register plus the rzc output), reusable by the zero-cross processor wrapper.
- The write register, counter, handshake and state machine stay in dtw_frame_writer.

## Test plan
- Basic frame: stream -3,-1,2,5,7,-4,-2,1 with in_valid every cycle.
  - Writes 2,5,7,-4,-2 (5 wrreq pulses).
  - frame_done=1 with frame_len=5, frame_err=0.
  - The sample 1 is not written.
- Ack handshake: hold frame_ack=0 for 10 cycles, then pulse it.
  - frame_done stays high and drop_cnt counts 10 valid samples.
  - Then ARM; no writes until the next negative-to-nonnegative transition.
- Overflow: preload the FIFO to usedw=126, then start a frame with 4 samples.
  - 2 writes occur; the third sample is not written.
  - overflow=1, frame_len=2, frame_err=1.
- Truncation with MAX_LEN=8: a 20-sample positive run after a crossing.
  - Exactly 8 wrreq pulses; frame_done with frame_len=8, frame_err=1.
- Reset mid-FILL: assert rst_geral after 3 writes.
  - All outputs are 0 asynchronously.
  - After release, a sample of -1 then 4 starts a new frame with 4 as the first write.
- Simultaneous events: frame_ack on the same edge as rzc.
  - The crossing is dropped and drop_cnt increments.
  - A frame starts only at the following rzc.

Source files
------------

// File: rtl/dtw_frame_writer_pkg.sv
// Shared definitions for the DTW sample path: default bus widths and the
// frame writer state encoding.
package dtw_frame_writer_pkg;

    localparam int unsigned DTW_DATA_W  = 16;
    localparam int unsigned DTW_USEDW_W = 7;
    localparam int unsigned DTW_DROP_W  = 16;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } fw_state_e;

endpackage

// File: rtl/zc_detect.sv
// Rising zero-crossing detector: remembers the sign of the last valid sample
// and flags a negative-to-nonnegative transition on the current one.
module zc_detect
    import dtw_frame_writer_pkg::*;
#(
    parameter int unsigned DATA_W = DTW_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              rzc_c_o
);

    logic prev_neg_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_neg_q <= 1'b0;
        end else if (in_valid_i) begin
            prev_neg_q <= in_data_i[DATA_W-1];
        end
    end

    assign rzc_c_o = in_valid_i & prev_neg_q & ~in_data_i[DATA_W-1];

endmodule

// File: rtl/dtw_frame_writer.sv
// Cuts the sample stream into rising-zero-crossing frames, writes each frame
// into the DTW FIFO and holds a frame-ready handshake for the controller.
module dtw_frame_writer
    import dtw_frame_writer_pkg::*;
#(
    parameter int unsigned DATA_W  = DTW_DATA_W,
    parameter int unsigned USEDW_W = DTW_USEDW_W,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic                  clk,
    input  logic                  rst_geral,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  fifo_full,
    input  logic [USEDW_W-1:0]    fifo_usedw,
    output logic [DATA_W-1:0]     fifo_data,
    output logic                  fifo_wrreq,
    output logic                  frame_done,
    input  logic                  frame_ack,
    output logic [USEDW_W-1:0]    frame_len,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [DTW_DROP_W-1:0] drop_cnt
);

    localparam int unsigned        DROP_W    = DTW_DROP_W;
    localparam logic [USEDW_W-1:0] USEDW_MAX = '1;
    localparam logic [USEDW_W-1:0] MAX_LEN_C = USEDW_W'(MAX_LEN);
    localparam bit                 ONE_SHOT  = (MAX_LEN == 1);

    fw_state_e           state_q;
    logic [DATA_W-1:0]   fifo_data_q;
    logic                fifo_wrreq_q;
    logic                frame_done_q;
    logic [USEDW_W-1:0]  frame_len_q;
    logic                frame_err_q;
    logic                overflow_q;
    logic [DROP_W-1:0]   drop_cnt_q;
    logic [DROP_W-1:0]   drop_cnt_d;
    logic [USEDW_W-1:0]  cnt_q;
    logic [USEDW_W-1:0]  cnt_d;
    logic                rzc_c;
    logic                eff_full_c;

    zc_detect #(
        .DATA_W (DATA_W)
    ) u_zc_detect (
        .clk_i      (clk),
        .rst_i      (rst_geral),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .rzc_c_o    (rzc_c)
    );

    // A write still sitting in the output register counts against the FIFO.
    assign eff_full_c = fifo_full | (fifo_wrreq_q & (fifo_usedw == USEDW_MAX));
    assign cnt_d      = cnt_q + USEDW_W'(1);
    assign drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + DROP_W'(1);

    always_ff @(posedge clk or posedge rst_geral) begin
        if (rst_geral) begin
            state_q      <= ST_ARM;
            fifo_data_q  <= '0;
            fifo_wrreq_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            cnt_q        <= '0;
        end else begin
            fifo_wrreq_q <= 1'b0;
            case (state_q)
                ST_ARM: begin
                    if (rzc_c) begin
                        fifo_wrreq_q <= 1'b1;
                        fifo_data_q  <= in_data;
                        cnt_q        <= USEDW_W'(1);
                        if (ONE_SHOT) begin
                            frame_len_q  <= MAX_LEN_C;
                            frame_err_q  <= 1'b1;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_HOLD;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                // Crossing beats full, full beats length limit.
                ST_FILL: begin
                    if (rzc_c) begin
                        frame_len_q  <= cnt_q;
                        frame_err_q  <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_HOLD;
                    end else if (in_valid) begin
                        if (eff_full_c) begin
                            overflow_q   <= 1'b1;
                            frame_len_q  <= cnt_q;
                            frame_err_q  <= 1'b1;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_HOLD;
                        end else begin
                            fifo_wrreq_q <= 1'b1;
                            fifo_data_q  <= in_data;
                            cnt_q        <= cnt_d;
                            if (cnt_d == MAX_LEN_C) begin
                                frame_len_q  <= MAX_LEN_C;
                                frame_err_q  <= 1'b1;
                                frame_done_q <= 1'b1;
                                state_q      <= ST_HOLD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (in_valid) begin
                        drop_cnt_q <= drop_cnt_d;
                    end
                    if (frame_ack) begin
                        frame_done_q <= 1'b0;
                        state_q      <= ST_ARM;
                    end
                end
                default: begin
                    state_q <= ST_ARM;
                end
            endcase
        end
    end

    assign fifo_data  = fifo_data_q;
    assign fifo_wrreq = fifo_wrreq_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_dtw_frame_writer.sv
// Scoreboard bench for dtw_frame_writer: a per-sample reference model queues
// expected FIFO writes and frame results; a monitor checks what the DUT shows.
module tb_dtw_frame_writer;

    localparam int DATA_W  = 16;
    localparam int USEDW_W = 7;
    localparam int MAX_LEN = 8;
    localparam int DEPTH   = 1 << USEDW_W;

    typedef struct packed {
        logic [USEDW_W-1:0] len;
        logic               err;
    } frame_t;

    logic               clk = 1'b0;
    logic               rst_geral = 1'b1;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_valid = 1'b0;
    logic               fifo_full;
    logic [USEDW_W-1:0] fifo_usedw;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_wrreq;
    logic               frame_done;
    logic               frame_ack = 1'b0;
    logic [USEDW_W-1:0] frame_len;
    logic               frame_err;
    logic               overflow;
    logic [15:0]        drop_cnt;

    int checks = 0;
    int failures = 0;

    dtw_frame_writer #(
        .DATA_W  (DATA_W),
        .USEDW_W (USEDW_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk        (clk),
        .rst_geral  (rst_geral),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .fifo_full  (fifo_full),
        .fifo_usedw (fifo_usedw),
        .fifo_data  (fifo_data),
        .fifo_wrreq (fifo_wrreq),
        .frame_done (frame_done),
        .frame_ack  (frame_ack),
        .frame_len  (frame_len),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // FIFO occupancy model (sclr tied to reset, preload for fill tests).
    int fifo_cnt = 0;
    bit pre_req = 1'b0;
    int pre_val = 0;
    always @(posedge clk or posedge rst_geral) begin
        if (rst_geral) fifo_cnt <= 0;
        else if (pre_req) fifo_cnt <= pre_val;
        else if (fifo_wrreq && fifo_cnt < DEPTH) fifo_cnt <= fifo_cnt + 1;
    end
    assign fifo_full  = (fifo_cnt >= DEPTH);
    assign fifo_usedw = USEDW_W'(fifo_cnt);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: modes 0 = waiting for crossing, 1 = collecting, 2 = holding.
    logic [DATA_W-1:0] exp_wr[$];
    frame_t            exp_frame[$];
    int                m_mode = 0;
    bit                m_prevneg = 1'b0;
    int                m_cnt = 0;
    int                m_occ = 0;
    int                m_drop = 0;
    bit                m_ovf = 1'b0;
    int                m_len = 0;
    bit                m_err = 1'b0;

    function automatic void m_write(input logic [DATA_W-1:0] d);
        exp_wr.push_back(d);
        m_occ++;
        m_cnt++;
    endfunction

    function automatic void m_end(input int len, input bit err);
        frame_t f;
        m_mode = 2;
        m_len  = len;
        m_err  = err;
        f.len  = USEDW_W'(len);
        f.err  = err;
        exp_frame.push_back(f);
    endfunction

    function automatic void model_step(input bit v, input logic [DATA_W-1:0] d, input bit ack);
        bit neg;
        bit rzc;
        neg = d[DATA_W-1];
        rzc = v && m_prevneg && !neg;
        case (m_mode)
            0: if (rzc) begin
                m_cnt  = 0;
                m_mode = 1;
                m_write(d);
                if (m_cnt == MAX_LEN) m_end(MAX_LEN, 1'b1);
            end
            1: if (rzc) begin
                m_end(m_cnt, 1'b0);
            end else if (v) begin
                if (m_occ >= DEPTH) begin
                    m_ovf = 1'b1;
                    m_end(m_cnt, 1'b1);
                end else begin
                    m_write(d);
                    if (m_cnt == MAX_LEN) m_end(MAX_LEN, 1'b1);
                end
            end
            default: begin
                if (v && m_drop < 65535) m_drop++;
                if (ack) m_mode = 0;
            end
        endcase
        if (v) m_prevneg = neg;
    endfunction

    function automatic void model_reset();
        exp_wr.delete();
        exp_frame.delete();
        m_mode = 0; m_prevneg = 1'b0; m_cnt = 0; m_occ = 0;
        m_drop = 0; m_ovf = 1'b0; m_len = 0; m_err = 1'b0;
    endfunction

    // Monitor: sampled on the falling edge, away from DUT updates.
    int                wr_count = 0;
    logic [DATA_W-1:0] last_wr = '0;
    logic              prev_done = 1'b0;
    always @(negedge clk) begin
        frame_t f;
        if (fifo_wrreq === 1'b1) begin
            wr_count++;
            last_wr = fifo_data;
            if (exp_wr.size() == 0) chk("unexpected_wrreq", 32'd1, 32'd0);
            else chk("wr_data", 32'(fifo_data), 32'(exp_wr.pop_front()));
        end
        if (frame_done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_frame.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                f = exp_frame.pop_front();
                chk("frame_len", 32'(frame_len), 32'(f.len));
                chk("frame_err", 32'(frame_err), 32'(f.err));
            end
        end
        prev_done = frame_done;
        chk("frame_done_level", 32'(frame_done), 32'(m_mode == 2));
        chk("overflow_level", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt_level", 32'(drop_cnt), 32'(m_drop));
        if (m_mode == 2) begin
            chk("frame_len_hold", 32'(frame_len), 32'(m_len));
            chk("frame_err_hold", 32'(frame_err), 32'(m_err));
        end
    end

    task automatic step_p(input bit v, input int d, input bit ack, input bit pre, input int pv);
        logic [DATA_W-1:0] dd;
        dd = DATA_W'(d);
        @(negedge clk);
        in_valid = v; in_data = dd; frame_ack = ack;
        pre_req = pre; pre_val = pv;
        @(posedge clk);
        model_step(v, dd, ack);
        if (pre) m_occ = pv;
    endtask

    task automatic s(input bit v, input int d, input bit ack);
        step_p(v, d, ack, 1'b0, 0);
    endtask

    task automatic settle();
        s(1'b0, 0, 1'b0);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_geral = 1'b1;
        in_valid = 1'b0; frame_ack = 1'b0; pre_req = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_geral = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int basic_stream[8] = '{-3, -1, 2, 5, 7, -4, -2, 1};

        do_reset();
        settle();
        chk("reset_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);

        // Basic frame
        wr0 = wr_count;
        foreach (basic_stream[i]) s(1'b1, basic_stream[i], 1'b0);
        settle();
        chk("basic_writes", 32'(wr_count - wr0), 32'd5);
        chk("basic_last_wr", 32'(last_wr), 32'hFFFE);
        chk("basic_done", 32'(frame_done), 32'd1);
        chk("basic_len", 32'(frame_len), 32'd5);
        chk("basic_err", 32'(frame_err), 32'd0);

        // Ack handshake: samples while holding are dropped
        for (int i = 0; i < 10; i++) s(1'b1, 3 + i, 1'b0);
        settle();
        chk("ack_drop10", 32'(drop_cnt), 32'd10);
        chk("ack_done_held", 32'(frame_done), 32'd1);
        wr0 = wr_count;
        s(1'b0, 0, 1'b1);
        s(1'b1, 5, 1'b0);
        s(1'b1, 6, 1'b0);
        settle();
        chk("ack_done_fell", 32'(frame_done), 32'd0);
        chk("ack_no_write", 32'(wr_count - wr0), 32'd0);
        s(1'b1, -5, 1'b0);
        s(1'b1, 6, 1'b0);
        settle();
        chk("ack_new_frame", 32'(last_wr), 32'd6);

        // Overflow against a nearly full FIFO
        do_reset();
        step_p(1'b0, 0, 1'b0, 1'b1, DEPTH - 2);
        wr0 = wr_count;
        s(1'b1, -1, 1'b0);
        s(1'b1, 10, 1'b0);
        s(1'b1, 11, 1'b0);
        s(1'b1, 12, 1'b0);
        settle();
        chk("ovf_writes", 32'(wr_count - wr0), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_len", 32'(frame_len), 32'd2);
        chk("ovf_err", 32'(frame_err), 32'd1);

        // Truncation at MAX_LEN
        do_reset();
        wr0 = wr_count;
        s(1'b1, -1, 1'b0);
        for (int i = 0; i < 20; i++) s(1'b1, i + 1, 1'b0);
        settle();
        chk("trunc_writes", 32'(wr_count - wr0), 32'(MAX_LEN));
        chk("trunc_len", 32'(frame_len), 32'(MAX_LEN));
        chk("trunc_err", 32'(frame_err), 32'd1);
        chk("trunc_drop", 32'(drop_cnt), 32'(20 - MAX_LEN));

        // Asynchronous reset in the middle of a frame
        do_reset();
        s(1'b1, -1, 1'b0);
        s(1'b1, 1, 1'b0);
        s(1'b1, 2, 1'b0);
        s(1'b1, 3, 1'b0);
        @(negedge clk);
        #2;
        rst_geral = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_async_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("rst_async_data", 32'(fifo_data), 32'd0);
        chk("rst_async_done", 32'(frame_done), 32'd0);
        chk("rst_async_len", 32'(frame_len), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_geral = 1'b0;
        wr0 = wr_count;
        s(1'b1, -1, 1'b0);
        s(1'b1, 4, 1'b0);
        settle();
        chk("rst_first_write", 32'(last_wr), 32'd4);
        chk("rst_write_count", 32'(wr_count - wr0), 32'd1);

        // Ack coinciding with a rising crossing
        do_reset();
        wr0 = wr_count;
        s(1'b1, -1, 1'b0);
        s(1'b1, 5, 1'b0);
        s(1'b1, -2, 1'b0);
        s(1'b1, 3, 1'b0);
        s(1'b1, -4, 1'b0);
        s(1'b1, 7, 1'b1);
        s(1'b1, 8, 1'b0);
        settle();
        chk("sim_drop", 32'(drop_cnt), 32'd2);
        chk("sim_armed", 32'(frame_done), 32'd0);
        chk("sim_no_write", 32'(wr_count - wr0), 32'd2);
        s(1'b1, -1, 1'b0);
        s(1'b1, 9, 1'b0);
        settle();
        chk("sim_next_frame", 32'(last_wr), 32'd9);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit ack;
            int d;
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) == 0) ? int'($signed(16'($urandom))) : $urandom_range(0, 20) - 10;
            ack = (m_mode == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
            if (m_mode == 2 && $urandom_range(0, 3) == 0)
                step_p(v, d, ack, 1'b1, $urandom_range(DEPTH - 12, DEPTH - 1) * ($urandom_range(0, 1)));
            else
                s(v, d, ack);
        end
        settle();
        chk("end_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("end_frame_queue_empty", 32'(exp_frame.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
